// File: rtl/moving_average_pkg.sv
// Shared constants and width helpers for the moving-average filter family.
package moving_average_pkg;

    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic int sum_width(input int width, input int log2_depth);
        return width + log2_depth;
    endfunction

endpackage

// File: rtl/moving_average_ring.sv
// Circular sample buffer of 2^LOG2_DEPTH entries; exposes the slot about to be
// overwritten (the oldest sample) combinationally.
module moving_average_ring
    import moving_average_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] oldest_o
);

    localparam int N     = 1 << LOG2_DEPTH;
    localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

    logic [WIDTH-1:0] mem_q [N];
    logic [PTR_W-1:0] wp_q;
    logic [PTR_W-1:0] wp_d;

    // Write-pointer next state: explicit wrap keeps N = 1 pinned at slot 0.
    always_comb begin
        wp_d = wp_q;
        if (clr_i) begin
            wp_d = '0;
        end else if (wr_en_i) begin
            wp_d = (wp_q == PTR_W'(N - 1)) ? '0 : wp_q + PTR_W'(1);
        end else begin
            wp_d = wp_q;
        end
    end

    // Pointer and sample storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q <= '0;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            if (clr_i) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (wr_en_i) begin
                mem_q[wp_q] <= wr_data_i;
            end
        end
    end

    assign oldest_o = mem_q[wp_q];

endmodule

// File: rtl/moving_average_window.sv
// Boxcar moving average over 2^LOG2_DEPTH signed samples with valid handshake,
// selectable rounding, synchronous clear and window-filled flag.
module moving_average_window
    import moving_average_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int ROUND      = ROUND_FLOOR
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             filled
);

    localparam int SW        = sum_width(WIDTH, LOG2_DEPTH);
    localparam int N         = 1 << LOG2_DEPTH;
    localparam int FILL_W    = LOG2_DEPTH + 1;
    localparam int RND_SHIFT = (LOG2_DEPTH > 0) ? LOG2_DEPTH - 1 : 0;
    localparam int RND_INT   = ((ROUND == ROUND_HALF_UP) && (LOG2_DEPTH > 0)) ? (1 << RND_SHIFT) : 0;
    localparam logic signed [SW:0] RND = (SW + 1)'(RND_INT);

    logic signed [SW-1:0] acc_q, acc_d, acc_next_s;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_next_s;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 filled_q, filled_d;
    logic [WIDTH-1:0]     oldest_s;
    logic signed [SW:0]   avg_full_s, avg_shift_s;
    logic [WIDTH-1:0]     avg_s;
    logic                 avg_unused_s;
    logic                 accept_s;

    assign accept_s = in_valid & ~clear;

    moving_average_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk_i     (system1000),
        .rst_n_i   (system1000_rstn),
        .clr_i     (clear),
        .wr_en_i   (accept_s),
        .wr_data_i (in_data),
        .oldest_o  (oldest_s)
    );

    // Upper bits are pure sign extension once the window sum is divided by N.
    assign acc_next_s   = acc_q + SW'($signed(in_data)) - SW'($signed(oldest_s));
    assign avg_full_s   = (SW + 1)'(acc_next_s) + RND;
    assign avg_shift_s  = avg_full_s >>> LOG2_DEPTH;
    assign avg_s        = avg_shift_s[WIDTH-1:0];
    assign avg_unused_s = ^avg_shift_s[SW:WIDTH];
    assign fill_next_s  = (fill_q == FILL_W'(N)) ? fill_q : fill_q + FILL_W'(1);

    // Next state: clear beats an accepted sample; idle holds data and drops valid.
    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        filled_d    = filled_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (clear) begin
            acc_d       = '0;
            fill_d      = '0;
            filled_d    = 1'b0;
            out_valid_d = 1'b0;
        end else if (in_valid) begin
            acc_d       = acc_next_s;
            fill_d      = fill_next_s;
            filled_d    = (fill_next_s == FILL_W'(N));
            out_valid_d = 1'b1;
            out_data_d  = avg_s;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Accumulator, fill counter and output registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            acc_q       <= '0;
            fill_q      <= '0;
            filled_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            filled_q    <= filled_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign filled    = filled_q;

endmodule

// File: tb/tb_moving_average_window.sv
// Scoreboard bench: floor and round-half-up instances share one stimulus stream
// and are compared against a window-of-samples reference model.
module tb_moving_average_window;

    localparam int WIDTH = 8;
    localparam int LOG2  = 2;
    localparam int N     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn, clear, in_valid;
    logic [WIDTH-1:0] in_data;
    logic             ov0, f0, ov1, f1;
    logic [WIDTH-1:0] od0, od1;

    moving_average_window #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2), .ROUND(0)) dut0 (
        .system1000(clk), .system1000_rstn(rstn), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .out_valid(ov0), .out_data(od0), .filled(f0));

    moving_average_window #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2), .ROUND(1)) dut1 (
        .system1000(clk), .system1000_rstn(rstn), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .out_valid(ov1), .out_data(od1), .filled(f1));

    typedef struct {
        int v;
        int f;
        int d0;
        int d1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   win[$];
    int   cnt;
    int   hold0, hold1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int t);
        int q;
        q = t / N;
        if ((t % N != 0) && (t < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int win_sum();
        int s;
        s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic model_flush();
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(0);
        cnt = 0;
    endtask

    // Drive one cycle, then record what the outputs must show after that edge.
    task automatic step(input int v, input int c, input int d);
        exp_t e;
        @(negedge clk);
        in_valid = v[0];
        clear    = c[0];
        in_data  = d[7:0];
        @(posedge clk);
        if (c != 0) begin
            model_flush();
            e.v = 0;
        end else if (v != 0) begin
            win.push_back(d);
            void'(win.pop_front());
            if (cnt < N) cnt++;
            hold0 = floor_div(win_sum());
            hold1 = floor_div(win_sum() + N / 2);
            e.v = 1;
        end else begin
            e.v = 0;
        end
        e.f  = (cnt == N) ? 1 : 0;
        e.d0 = hold0;
        e.d1 = hold1;
        sb.push_back(e);
    endtask

    task automatic expect_out(input string name, input int e0, input int e1);
        #1;
        chk({name, "_floor"}, int'($signed(od0)), e0);
        chk({name, "_round"}, int'($signed(od1)), e1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        rstn     = 1'b0;
        #1;
        chk("rst_out_valid", int'(ov0) + int'(ov1), 0);
        chk("rst_out_data",  int'(od0) + int'(od1), 0);
        chk("rst_filled",    int'(f0) + int'(f1), 0);
        model_flush();
        hold0 = 0;
        hold1 = 0;
        @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    // Monitor: each entry pushed at an edge is compared at the following falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("out_valid_floor", int'(ov0), mon_e.v);
                chk("out_valid_round", int'(ov1), mon_e.v);
                chk("filled_floor",    int'(f0), mon_e.f);
                chk("filled_round",    int'(f1), mon_e.f);
                chk("out_data_floor",  int'($signed(od0)), mon_e.d0);
                chk("out_data_round",  int'($signed(od1)), mon_e.d1);
            end
        end
    end

    initial begin
        rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        model_flush();
        hold0 = 0;
        hold1 = 0;
        #12;
        chk("init_out_valid", int'(ov0), 0);
        chk("init_out_data",  int'(od0), 0);
        chk("init_filled",    int'(f0), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Ramp: 4, 8, 12, 16, 20 -> 1, 3, 6, 10, 14 (floor)
        step(1, 0, 4);  expect_out("ramp1", 1, 1);
        step(1, 0, 8);  expect_out("ramp2", 3, 3);
        step(1, 0, 12); expect_out("ramp3", 6, 6);
        chk("ramp_not_filled", int'(f0), 0);
        step(1, 0, 16); expect_out("ramp4", 10, 10);
        chk("ramp_filled", int'(f0), 1);
        step(1, 0, 20); expect_out("ramp5", 14, 14);

        // Signed floor vs round-half-up
        do_reset();
        step(1, 0, -1); expect_out("neg_one", -1, 0);
        do_reset();
        step(1, 0, 1);
        step(1, 0, 1);  expect_out("two_ones", 0, 1);

        // Extremes and the full-scale transition
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, -128);
        expect_out("all_min", -128, -128);
        for (int i = 0; i < 4; i++) step(1, 0, 127);
        expect_out("all_max", 127, 127);

        // Gaps between accepted samples
        do_reset();
        step(1, 0, 8);  expect_out("gap_first", 2, 2);
        for (int i = 0; i < 3; i++) step(0, 0, 77);
        step(1, 0, 8);  expect_out("gap_second", 4, 4);

        // Clear overrides a concurrent valid sample
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 40);
        step(1, 1, 99);
        #1;
        chk("clear_out_valid", int'(ov0), 0);
        chk("clear_filled",    int'(f0), 0);
        step(1, 0, 40); expect_out("after_clear", 10, 10);

        // Asynchronous reset in the middle of a stream
        step(1, 0, 100);
        step(1, 0, -50);
        do_reset();
        step(1, 0, 16); expect_out("after_rst", 4, 4);

        // Randomised traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            step(($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 31) == 0) ? 1 : 0,
                 int'($signed(r)));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moving_average_window.md
# moving_average_window

Parametrised successor to the fixed 8-bit moving-average top entity. It computes a boxcar moving average of a signed sample stream over a window of 2^LOG2_DEPTH samples. It adds four things the fixed block lacks: a valid handshake, selectable rounding, a synchronous clear and a window-filled flag. It sits in the same single-clock `system1000` domain and is a drop-in replacement wherever a filtered sample stream is needed.

## Interface
- `WIDTH`, 8: sample width, signed two's complement, ≥2.
- `LOG2_DEPTH`, 2: window length N = 2^LOG2_DEPTH. Range 0..8.
- `ROUND`, 0: 0 = floor (arithmetic shift); 1 = round half up (add 2^(LOG2_DEPTH-1) before the shift).

Ports:
- `system1000`  in  1  clock, rising edge.
- `system1000_rstn`  in  1  reset; asynchronous assertion, active-low.
- `clear`  in  1  synchronous flush of window, sum and flags.
- `in_valid`  in  1  `in_data` is accepted this cycle.
- `in_data`  in  WIDTH  signed input sample.
- `out_valid`  out  1  `out_data` holds a new average.
- `out_data`  out  WIDTH  signed average of the last N accepted samples.
- `filled`  out  1  N samples have been accepted since the last reset or clear.

## Operation
- State:
  - Ring buffer of N samples, all zero at reset.
  - Write pointer `wp` (LOG2_DEPTH bits).
  - Running sum `acc`, signed, WIDTH+LOG2_DEPTH bits.
  - Fill counter, saturating at N.
- Accepted sample (`in_valid`=1, `clear`=0), all in the same cycle:
  - acc ← acc + in_data − buf[wp]
  - buf[wp] ← in_data
  - wp ← wp+1, wrapping mod N
  - fill count increments; saturates at N.
- Average: avg = (acc_next + (ROUND ? 2^(LOG2_DEPTH-1) : 0)) >>> LOG2_DEPTH.
  - Computed in WIDTH+LOG2_DEPTH+1 bits, then truncated to WIDTH.
  - Truncation is lossless by construction, so no saturation logic is required.
- Warm-up: before `filled`, the average includes the zero-initialised slots. This behaviour is intentional and matches the legacy block.
- LOG2_DEPTH=0: the block reduces to a registered pass-through; ROUND has no effect.
- `clear`=1 (overrides `in_valid`):
  - buffer, acc, wp and fill count go to 0
  - `filled`=0, `out_valid`=0
  - `out_data` holds its last value
  - the sample presented in that cycle is dropped.
- `in_valid`=0: no state change; `out_valid`=0 next cycle; `out_data` holds.
- No backpressure: the block accepts one sample every cycle, and downstream must keep up.

## Timing
- Latency: 1 cycle. A sample accepted at edge k produces `out_valid`=1 and its average after edge k.
- Throughput: 1 sample/cycle.
- Reset values: `out_valid`=0, `out_data`=0, `filled`=0; all internal state is 0.
- Reset asserted mid-stream: all state clears immediately (asynchronously). The first sample after release is averaged against an all-zero window.
- `filled` rises in the same cycle as `out_valid` for the Nth accepted sample and stays high until reset or clear.
- Pointer wrap: the slot overwritten on wrap is exactly the sample subtracted. There is no off-by-one at wp = N−1 → 0.

## Structure
- Shared package `moving_average_pkg`:
  - constant function `sum_width(WIDTH, LOG2_DEPTH)` = WIDTH+LOG2_DEPTH
  - round-mode constants `ROUND_FLOOR`=0, `ROUND_HALF_UP`=1.
- Sub-module `moving_average_ring`:
  - an N×WIDTH circular buffer with write pointer
  - outputs the oldest sample (buf[wp]) combinationally
  - one write port, reset-clearable.
- The top level holds the accumulator, the rounding/shift logic and the output registers.

## Test plan
- WIDTH=8, LOG2_DEPTH=2, ROUND=0: inputs 4, 8, 12, 16, 20 on consecutive cycles → `out_data` 1, 3, 6, 10, 14 one cycle later. `filled` rises with the 10.
- Signed floor vs round: a single sample −1 from reset → −1 with ROUND=0 and 0 with ROUND=1. Samples 1, 1 → 0 with ROUND=0 and 1 with ROUND=1.
- Extremes: four × −128 → −128; then four × 127 → 127 under both ROUND modes, with no overflow on the transition.
- Gaps: 8, (idle ×3), 8 → `out_valid` only on accepted cycles, outputs 2 then 4; `out_data` holds during idle cycles.
- Clear: after six samples of 40, assert `clear` together with `in_valid` (data 99) → `out_valid`=0 and `filled`=0. The next sample 40 yields 10.
- Async reset mid-stream: assert `system1000_rstn`=0 between edges → outputs go to 0 immediately. After release, sample 16 → 4.
